// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus: the raw keyboard lines and rx_en towards the receiver,
// plus the received byte, its strobe and its error flags coming back.
interface ps2_rx_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output ps2c, ps2d, rx_en,
    input  dout, rx_done_tick, parity_err, frame_err
  );

  modport slave (
    input  ps2c, ps2d, rx_en,
    output dout, rx_done_tick, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 serial receiver: synchronizes and deglitches the keyboard lines,
// deserializes 11-bit frames and strobes out each byte with its error flags.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic    clk,
  input  logic    rst,
  ps2_rx_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, LOAD} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_c_sync, r_d_sync;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_fc, r_fc_prev;
  logic                  w_fall, w_d;
  logic [10:0]           r_b, w_b_shift;
  logic [3:0]            r_n, w_n_nxt;
  logic [TW-1:0]         r_tcnt;
  logic                  w_shift, w_load, w_tclr;
  logic [7:0]            r_dout;
  logic                  r_parity_err, r_frame_err;

  assign w_d       = r_d_sync[1];
  assign w_fall    = r_fc_prev & ~r_fc;
  assign w_b_shift = {w_d, r_b[10:1]};

  // Lines idle high, so synchronizers and filter come out of reset at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_sync  <= 2'b11;
      r_d_sync  <= 2'b11;
      r_filt    <= '1;
      r_fc      <= 1'b1;
      r_fc_prev <= 1'b1;
    end else begin
      r_c_sync  <= {r_c_sync[0], bus.ps2c};
      r_d_sync  <= {r_d_sync[0], bus.ps2d};
      r_filt    <= {r_c_sync[1], r_filt[FILTER_LEN-1:1]};
      r_fc_prev <= r_fc;
      if (&r_filt)
        r_fc <= 1'b1;
      else if (~|r_filt)
        r_fc <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_tclr      = 1'b0;
    w_n_nxt     = r_n;
    case (r_state)
      IDLE: begin
        w_tclr = 1'b1;
        if (w_fall && bus.rx_en && !w_d) begin
          w_shift     = 1'b1;
          w_n_nxt     = 4'd9;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        // A fall in the same cycle as the timeout takes priority.
        if (w_fall) begin
          w_shift = 1'b1;
          w_tclr  = 1'b1;
          if (r_n == 4'd0) begin
            w_load      = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_n_nxt = r_n - 4'd1;
          end
        end else if (r_tcnt == TMAX) begin
          w_state_nxt = IDLE;
        end
      end
      LOAD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b    <= '0;
      r_n    <= '0;
      r_tcnt <= '0;
    end else begin
      r_n    <= w_n_nxt;
      r_tcnt <= w_tclr ? '0 : r_tcnt + TW'(1);
      if (w_shift)
        r_b <= w_b_shift;
    end
  end

  // Outputs capture the frame including the stop bit being shifted in now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= 8'h00;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else if (w_load) begin
      r_dout       <= w_b_shift[8:1];
      r_parity_err <= ~^w_b_shift[9:1];
      r_frame_err  <= ~w_b_shift[10];
    end
  end

  assign bus.dout         = r_dout;
  assign bus.parity_err   = r_parity_err;
  assign bus.frame_err    = r_frame_err;
  assign bus.rx_done_tick = (r_state == LOAD);

endmodule
